// File: rtl/eqa_iir_biquad.sv
// Single-section IIR biquad with one serial multiply-accumulate over five taps.
// Coefficients are loaded into a shadow set and committed to the active set atomically.
module eqa_iir_biquad #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 18,
  parameter int unsigned COEFF_FRAC  = 16,
  parameter int unsigned ACC_WIDTH   = 40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic                          coeff_we,
  input  logic                          coeff_set,
  input  logic signed [COEFF_WIDTH-1:0] coeff_a,
  input  logic signed [COEFF_WIDTH-1:0] coeff_b,
  output logic                          input_ready,
  input  logic                          inpvalid,
  input  logic signed [DATA_WIDTH-1:0]  din,
  output logic                          outvalid,
  output logic signed [DATA_WIDTH-1:0]  dout
);

  localparam int unsigned ProdWidth = DATA_WIDTH + COEFF_WIDTH;
  localparam logic signed [COEFF_WIDTH-1:0] CoeffOne  = COEFF_WIDTH'(1 << COEFF_FRAC);
  localparam logic signed [ACC_WIDTH-1:0]   RoundHalf = ACC_WIDTH'(1 << (COEFF_FRAC - 1));
  localparam logic signed [ACC_WIDTH-1:0]   SatMax    = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0]   SatMin    = ACC_WIDTH'(-(1 << (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [1:0] ptr_q, ptr_d;
  logic       pend_q, pend_d;
  logic       outvalid_q, outvalid_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [DATA_WIDTH-1:0]  y1_q, y1_d, y2_q, y2_d, dout_q, dout_d;
  logic signed [COEFF_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic signed [COEFF_WIDTH-1:0] sh_b0_q, sh_b0_d, sh_b1_q, sh_b1_d, sh_b2_q, sh_b2_d;
  logic signed [COEFF_WIDTH-1:0] sh_a1_q, sh_a1_d, sh_a2_q, sh_a2_d;

  logic signed [DATA_WIDTH-1:0]  mac_x;
  logic signed [COEFF_WIDTH-1:0] mac_c;
  logic                          mac_neg;
  logic signed [ProdWidth-1:0]   prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext, mac_sum, rounded, shifted;
  logic signed [DATA_WIDTH-1:0]  y_sat;
  logic                          commit;

  // Tap order: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2
  always_comb begin
    mac_x   = '0;
    mac_c   = '0;
    mac_neg = 1'b0;
    unique case (k_q)
      3'd0: begin mac_x = x_q;  mac_c = b0_q; end
      3'd1: begin mac_x = x1_q; mac_c = b1_q; end
      3'd2: begin mac_x = x2_q; mac_c = b2_q; end
      3'd3: begin mac_x = y1_q; mac_c = a1_q; mac_neg = 1'b1; end
      3'd4: begin mac_x = y2_q; mac_c = a2_q; mac_neg = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = ProdWidth'(mac_x) * ProdWidth'(mac_c);
  assign prod_ext = ACC_WIDTH'(prod);
  assign mac_sum  = mac_neg ? (acc_q - prod_ext) : (acc_q + prod_ext);
  assign rounded  = acc_q + RoundHalf;
  assign shifted  = rounded >>> COEFF_FRAC;

  always_comb begin
    if (shifted > SatMax) begin
      y_sat = SatMax[DATA_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      y_sat = SatMin[DATA_WIDTH-1:0];
    end else begin
      y_sat = shifted[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ptr_d      = ptr_q;
    pend_d     = pend_q;
    outvalid_d = 1'b0;
    acc_d      = acc_q;
    x_d        = x_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    y1_d       = y1_q;
    y2_d       = y2_q;
    dout_d     = dout_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    sh_b0_d    = sh_b0_q;
    sh_b1_d    = sh_b1_q;
    sh_b2_d    = sh_b2_q;
    sh_a1_d    = sh_a1_q;
    sh_a2_d    = sh_a2_q;
    commit     = 1'b0;

    if (coeff_we && (ptr_q != 2'd3)) begin
      unique case (ptr_q)
        2'd0: sh_b0_d = coeff_b;
        2'd1: begin sh_b1_d = coeff_b; sh_a1_d = coeff_a; end
        2'd2: begin sh_b2_d = coeff_b; sh_a2_d = coeff_a; end
        default: ;
      endcase
      ptr_d = ptr_q + 2'd1;
    end

    unique case (state_q)
      StIdle: begin
        commit = coeff_set;
        if (inpvalid) begin
          x_d     = din;
          k_d     = '0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = mac_sum;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd4) begin
          state_d = StOut;
        end
      end
      StOut: begin
        commit     = coeff_set | pend_q;
        dout_d     = y_sat;
        outvalid_d = 1'b1;
        x2_d       = x1_q;
        x1_d       = x_q;
        y2_d       = y1_q;
        y1_d       = y_sat;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A commit requested mid-computation waits for the return to idle
    if (commit) begin
      pend_d = 1'b0;
    end else if (coeff_set && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end

    // Commit sees any write made on the same edge, and restarts the filter from rest
    if (commit) begin
      b0_d  = sh_b0_d;
      b1_d  = sh_b1_d;
      b2_d  = sh_b2_d;
      a1_d  = sh_a1_d;
      a2_d  = sh_a2_d;
      ptr_d = '0;
      x1_d  = '0;
      x2_d  = '0;
      y1_d  = '0;
      y2_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      outvalid_q <= 1'b0;
      acc_q      <= '0;
      x_q        <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      dout_q     <= '0;
      b0_q       <= CoeffOne;
      b1_q       <= '0;
      b2_q       <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      sh_b0_q    <= '0;
      sh_b1_q    <= '0;
      sh_b2_q    <= '0;
      sh_a1_q    <= '0;
      sh_a2_q    <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      k_q        <= k_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      outvalid_q <= outvalid_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      y1_q       <= y1_d;
      y2_q       <= y2_d;
      dout_q     <= dout_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      sh_b0_q    <= sh_b0_d;
      sh_b1_q    <= sh_b1_d;
      sh_b2_q    <= sh_b2_d;
      sh_a1_q    <= sh_a1_d;
      sh_a2_q    <= sh_a2_d;
    end
  end

  // A result pulse parked by ce=0 is emitted once ce returns
  assign outvalid    = outvalid_q & ce;
  assign input_ready = (state_q == StIdle) & ce & ~reset;
  assign dout        = dout_q;

endmodule
